// File: rtl/des_f_serial.sv
// des_f_serial: time-multiplexed DES round function f(R,K) = P(S(E(R) xor K)),
// evaluating LOOKUPS S-boxes per cycle behind valid/ready handshakes.
module des_f_serial #(
    parameter int LOOKUPS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:32] r_in,
    input  logic [1:48] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] f_out
);
    localparam int NSTEP = 8 / LOOKUPS;

    if (LOOKUPS != 1 && LOOKUPS != 2 && LOOKUPS != 4 && LOOKUPS != 8) begin : g_bad_lookups
        $error("des_f_serial: LOOKUPS must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [1:48] x_q, x_d;
    logic [3:0]  s_q [8];
    logic [3:0]  s_d [8];
    logic [1:32] f_q, f_d;
    logic [3:0]  sb [8];
    logic [2:0]  g;

    function automatic logic [1:48] e_exp(input logic [1:32] r);
        return {r[32], r[1:5], r[4:9], r[8:13], r[12:17], r[16:21], r[20:25], r[24:29], r[28:32], r[1]};
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] s);
        return {s[16], s[7],  s[20], s[21], s[29], s[12], s[28], s[17],
                s[1],  s[15], s[23], s[26], s[5],  s[18], s[31], s[10],
                s[2],  s[8],  s[24], s[14], s[32], s[27], s[3],  s[9],
                s[19], s[13], s[30], s[6],  s[22], s[11], s[4],  s[25]};
    endfunction

    // Each box always sees its own group; lanes pick which box results to keep by step.
    SBox1 u_sbox1 (.b_i(x_q[1:6]),   .s_o(sb[0]));
    SBox2 u_sbox2 (.b_i(x_q[7:12]),  .s_o(sb[1]));
    SBox3 u_sbox3 (.b_i(x_q[13:18]), .s_o(sb[2]));
    SBox4 u_sbox4 (.b_i(x_q[19:24]), .s_o(sb[3]));
    SBox5 u_sbox5 (.b_i(x_q[25:30]), .s_o(sb[4]));
    SBox6 u_sbox6 (.b_i(x_q[31:36]), .s_o(sb[5]));
    SBox7 u_sbox7 (.b_i(x_q[37:42]), .s_o(sb[6]));
    SBox8 u_sbox8 (.b_i(x_q[43:48]), .s_o(sb[7]));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        x_d     = x_q;
        s_d     = s_q;
        f_d     = f_q;
        g       = '0;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = e_exp(r_in) ^ subkey;
                step_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                for (int j = 0; j < LOOKUPS; j++) begin
                    g      = 3'(int'(step_q) * LOOKUPS + j);
                    s_d[g] = sb[g];
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'(NSTEP - 1)) begin
                    step_d  = '0;
                    f_d     = p_perm({s_d[0], s_d[1], s_d[2], s_d[3], s_d[4], s_d[5], s_d[6], s_d[7]});
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            x_q     <= '0;
            s_q     <= '{default: '0};
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            x_q     <= x_d;
            s_q     <= s_d;
            f_q     <= f_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign f_out     = f_q;
endmodule

// Standard DES S-boxes: row = outer bits, column = inner four bits.
module SBox1 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

module SBox2 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

module SBox3 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

module SBox4 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

module SBox5 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

module SBox6 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

module SBox7 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

module SBox8 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    assign s_o = T[{b_i[5], b_i[0], b_i[4:1]}];
endmodule

// File: tb/tb_des_f_serial.sv
// tb_des_f_serial: drives LOOKUPS=1/2/4/8 instances with known DES round vectors,
// backpressure, ignored operands, mid-run reset and random operands against a reference f(R,K).
module tb_des_f_serial;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [4];
    logic        out_ready [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic [1:32] f_out     [4];
    logic [1:32] r_in;
    logic [1:48] subkey;
    int          n_cmp = 0;
    int          n_err = 0;

    localparam logic [31:0] R1 = 32'hF0AAF0AA, F1 = 32'h234AA9BB;
    localparam logic [47:0] K1 = 48'h1B02EFFC7072;
    localparam logic [31:0] R2 = 32'hEF4A6544, F2 = 32'h3CAB87A3;
    localparam logic [47:0] K2 = 48'h79AED9DBC9E5;

    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                                16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam logic [0:511][3:0] SB = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        des_f_serial #(.LOOKUPS(1 << i)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid[i]), .in_ready(in_ready[i]),
            .r_in(r_in), .subkey(subkey), .out_valid(out_valid[i]), .out_ready(out_ready[i]),
            .f_out(f_out[i])
        );
    end

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, f;
        logic [5:0]  b;
        for (int i = 1; i <= 48; i++) x[48-i] = r[32-E_T[i-1]];
        x = x ^ k;
        for (int n = 0; n < 8; n++) begin
            b = x[47-6*n -: 6];
            s[31-4*n -: 4] = SB[9'(n * 64) + {3'b000, b[5], b[0], b[4:1]}];
        end
        for (int i = 1; i <= 32; i++) f[32-i] = s[32-P_T[i-1]];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input int d, input logic [31:0] r, input logic [47:0] k, input logic [31:0] exp, input int stall);
        int n = 0;
        while (!in_ready[d] && n < 20) begin
            tick();
            n++;
        end
        check("in_ready before accept", 64'(in_ready[d]), 64'(1));
        r_in = r;
        subkey = k;
        in_valid[d] = 1'b1;
        out_ready[d] = stall == 0;
        tick();
        in_valid[d] = 1'b0;
        n = 0;
        while (!out_valid[d] && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("latency L%0d", 1 << d), 64'(n), 64'(8 >> d));
        check($sformatf("f_out L%0d", 1 << d), 64'(f_out[d]), 64'(exp));
        for (int c = 0; c < stall; c++) begin
            tick();
            check("stall out_valid", 64'(out_valid[d]), 64'(1));
            check("stall f_out", 64'(f_out[d]), 64'(exp));
            check("stall in_ready", 64'(in_ready[d]), 64'(0));
        end
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        check("out_valid after handshake", 64'(out_valid[d]), 64'(0));
        check("in_ready after handshake", 64'(in_ready[d]), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [47:0] k;
        rst = 1'b1;
        r_in = '0;
        subkey = '0;
        for (int d = 0; d < 4; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            check("reset in_ready", 64'(in_ready[d]), 64'(1));
            check("reset out_valid", 64'(out_valid[d]), 64'(0));
            check("reset f_out", 64'(f_out[d]), 64'(0));
        end
        rst = 1'b0;
        tick();

        op(0, R1, K1, F1, 0);
        for (int d = 0; d < 4; d++) op(d, R2, K2, F2, 0);
        op(0, R1, K1, F1, 20);

        // Operands presented during RUN and on the DONE handshake edge must be ignored.
        r_in = R1;
        subkey = K1;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            r_in = $urandom;
            subkey = {16'($urandom), $urandom};
            tick();
            check("held in_valid in_ready", 64'(in_ready[0]), 64'(0));
        end
        r_in = R2;
        subkey = K2;
        tick();
        check("held in_valid out_valid", 64'(out_valid[0]), 64'(1));
        check("held in_valid f_out", 64'(f_out[0]), 64'(F1));
        tick();
        check("no accept on handshake edge", 64'(in_ready[0]), 64'(1));
        check("handshake out_valid", 64'(out_valid[0]), 64'(0));
        tick();
        check("second accept", 64'(in_ready[0]), 64'(0));
        in_valid[0] = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("second out_valid", 64'(out_valid[0]), 64'(1));
        check("second f_out", 64'(f_out[0]), 64'(F2));
        tick();
        out_ready[0] = 1'b0;

        // Reset at step 3 discards the operation and clears f_out.
        r_in = R2;
        subkey = K2;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-run reset in_ready", 64'(in_ready[0]), 64'(1));
        check("mid-run reset out_valid", 64'(out_valid[0]), 64'(0));
        check("mid-run reset f_out", 64'(f_out[0]), 64'(0));
        op(0, R1, K1, F1, 2);

        for (int t = 0; t < 250; t++) begin
            for (int d = 0; d < 4; d++) begin
                r = $urandom;
                k = {16'($urandom), $urandom};
                op(d, r, k, ref_f(r, k), int'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/des_f_serial.md
Name: des_f_serial

Overview:
- Time-multiplexed DES round function f(R,K) = P(S(E(R) xor K)).
- Sits between the round-key/Feistel datapath (upstream) and the per-box substitution modules SBox1..SBox8; it feeds each S-box its 6-bit group and consumes the 4-bit results.
- Evaluates LOOKUPS S-boxes per cycle, collects the nibbles, applies P, and presents a 32-bit result through a valid/ready handshake.
- Trades area for latency in area-constrained iterative DES builds.

Parameters:
- LOOKUPS, 1: S-boxes evaluated per cycle. Legal values 1, 2, 4, 8; any other value is a compile-time error. Run length is NSTEP = 8/LOOKUPS cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  r_in/subkey valid
- in_ready  out  1  block can accept an operand
- r_in  in  [1:32]  right half R, DES bit numbering (bit 1 = MSB)
- subkey  in  [1:48]  round subkey K, bit 1 = MSB
- out_valid  out  1  f_out valid
- out_ready  in  1  consumer accepts f_out
- f_out  out  [1:32]  P-permuted result

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst sampled high at a clk edge, in any state):
  - state to IDLE, step counter to 0, x_reg and s_reg to 0.
  - Outputs: in_ready=1, out_valid=0, f_out=0.
  - An operation in flight is discarded.
- States IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: x_reg <= E(r_in) xor subkey, using the standard DES 48-entry E table; step <= 0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge, for j in 0..LOOKUPS-1 with g = step*LOOKUPS + j: group g (bits 6g+1..6g+6 of x_reg) goes to SBox(g+1); its 4-bit output is written to s_reg bits 4g+1..4g+4.
  - S-box row = bits 1 and 6 of the group; column = bits 2..5.
  - step increments by 1. On the edge where step == NSTEP-1: f_out <= P(s_reg with the final nibbles merged in), using the standard DES 32-entry P table; step wraps to 0; go to DONE.
  - in_valid is ignored while in RUN.
- DONE:
  - out_valid=1, in_ready=0.
  - f_out is held stable until out_valid & out_ready; then go to IDLE.
  - No new operand is accepted on the same edge. The next accept is at the earliest one cycle later.
- Latency: accept at edge T gives out_valid high from edge T+NSTEP. Throughput is one result per NSTEP+2 cycles with out_ready held high.
- f_out keeps its last value in IDLE and RUN. It is updated only on RUN to DONE and cleared only by rst.
- out_ready while not in DONE has no effect. in_valid low in IDLE stays in IDLE.
- No arithmetic; XOR and fixed bit permutations only. Bit 1 is always the MSB of every vector.
- Implementation uses the existing SBox1..SBox8 modules:
  - LOOKUPS=8: all eight instantiated, with no muxing.
  - LOOKUPS<8: each of the LOOKUPS lanes selects among its 8/LOOKUPS boxes by step.

Test Plan:
- LOOKUPS=1, r_in=F0AAF0AA, subkey=1B02EFFC7072 (hex), out_ready=1 -> x_reg=6117BA866527, S output 5C82B597, f_out=234AA9BB with out_valid rising exactly 8 cycles after the accept edge, high for 1 cycle.
- LOOKUPS=1, r_in=EF4A6544, subkey=79AED9DBC9E5 -> f_out=3CAB87A3. Repeat for LOOKUPS=2/4/8: same f_out, out_valid latency 4/2/1 cycles.
- Backpressure: first vector with out_ready=0 for 20 cycles -> out_valid stays 1, f_out stays 234AA9BB, in_ready stays 0. Pulse out_ready -> IDLE next edge, in_ready=1.
- in_valid held high through RUN with changing r_in -> those operands are ignored and the result still matches the first operand. A second operand is accepted only after the DONE handshake.
- Assert rst for one edge in mid-RUN (step=3) -> next cycle in_ready=1, out_valid=0, f_out=0. A new operation then produces the correct result.
- Back-to-back 1000 random (r_in, subkey) pairs with random out_ready stalls -> every f_out equals the software reference f(R,K). No result is lost or duplicated.
